// File: rtl/result_serializer.sv
// result_serializer: FIFO-buffered ALU results, emitted as two 16-bit beats per word
// (low half first) over a valid/ready handshake, with a sticky overflow flag.
module result_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_ula,
  input  logic                     rst,
  input  logic [31:0]              in_data,
  input  logic                     in_valid,
  input  logic                     clr_ovf,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [15:0]              words_sent
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     hold_q, hold_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     words_sent_q, words_sent_d;
  logic            push, pop, drop, hs_high;

  always_comb begin
    hs_high      = state_q == HIGH && out_ready;
    // the hold register reloads from the FIFO in IDLE or on the final beat's handshake
    pop          = count_q != '0 && (state_q == IDLE || hs_high);
    push         = in_valid && (count_q != FULL_CNT || pop);
    drop         = in_valid && !push;
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    hold_d       = pop ? mem_q[rd_ptr_q] : hold_q;
    overflow_d   = drop || (overflow_q && !clr_ovf);
    words_sent_d = words_sent_q + 16'(hs_high);
    state_d      = pop ? LOW :
                   (state_q == LOW && out_ready) ? HIGH :
                   hs_high ? IDLE : state_q;
  end

  always_ff @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      overflow_q   <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      overflow_q   <= overflow_d;
      words_sent_q <= words_sent_d;
    end
  end

  always_ff @(posedge clk_ula) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid  = state_q != IDLE;
  assign out_last   = state_q == HIGH;
  assign out_data   = state_q == HIGH ? hold_q[31:16] : state_q == LOW ? hold_q[15:0] : '0;
  assign count      = count_q;
  assign full       = count_q == FULL_CNT;
  assign empty      = count_q == '0;
  assign overflow   = overflow_q;
  assign words_sent = words_sent_q;
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed stimulus with a beat scoreboard checked by an
// independent monitor on the falling edge.
module tb_result_serializer;
  logic        clk_ula = 1'b0;
  logic        rst, in_valid, clr_ovf, out_ready;
  logic [31:0] in_data;
  logic [15:0] out_data, words_sent;
  logic        out_valid, out_last, full, empty, overflow;
  logic [2:0]  count;

  typedef struct packed {logic l; logic [15:0] d;} beat_t;
  beat_t       sb[$];
  int          tests = 0, fails = 0;
  logic [15:0] exp_ws = 0;

  result_serializer #(.DEPTH(4)) dut (
    .clk_ula(clk_ula), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .clr_ovf(clr_ovf), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .words_sent(words_sent)
  );

  always #5 clk_ula = ~clk_ula;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ula);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] w);
    sb.push_back('{l: 1'b0, d: w[15:0]});
    sb.push_back('{l: 1'b1, d: w[31:16]});
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (sb.size() != 0 && k < n) begin
      step();
      k++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // a beat seen valid&ready on the falling edge is accepted on the next rising edge
  always @(negedge clk_ula) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL beat_unexpected: got data %h last %b, expected no beat", out_data, out_last);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat", {15'd0, out_last, out_data}, {15'd0, e.l, e.d});
        if (e.l) exp_ws++;
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; clr_ovf = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_words_sent", words_sent, 0);
    rst = 1'b1;
    step();

    // single word and 2-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; expect_word(32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    chk("lat_t_valid", out_valid, 0);
    step();
    chk("lat_t1_valid", out_valid, 1);
    chk("lat_t1_data", out_data, 16'hBEEF);
    drain(10);
    chk("single_words_sent", words_sent, exp_ws);
    chk("single_ws_one", words_sent, 1);
    chk("single_empty", empty, 1);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h12345678; expect_word(32'h12345678);
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", out_data, 16'h5678);
      chk("bp_valid", out_valid, 1);
      chk("bp_last", out_last, 0);
      step();
    end
    out_ready = 1'b1;
    drain(10);
    chk("bp_words_sent", words_sent, exp_ws);

    // overflow: 6 pushes, word 6 dropped
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 32'hA0000000 | i;
      if (i <= 5) expect_word(32'hA0000000 | i);
      step();
    end
    in_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 4);
    chk("ovf_hold_data", out_data, 16'h0001);
    step();
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; in_valid = 1'b1; in_data = 32'hBAD0BAD0;
    step();
    clr_ovf = 1'b0; in_valid = 1'b0;
    chk("ovf_drop_wins", overflow, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    chk("ovf_count_kept", count, 4);

    // full FIFO with push coinciding with the HIGH-beat pop
    out_ready = 1'b1;
    step();
    chk("fwp_in_high", out_last, 1);
    in_valid = 1'b1; in_data = 32'hC0DE0007; expect_word(32'hC0DE0007);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fwp_count", count, 4);
    chk("fwp_full", full, 1);
    chk("fwp_overflow", overflow, 0);
    chk("fwp_next_low", out_data, 16'h0002);
    out_ready = 1'b1;
    drain(40);
    chk("fwp_words_sent", words_sent, exp_ws);
    chk("fwp_empty", empty, 1);

    // back-to-back words, no bubbles
    expect_word(32'h11112222); expect_word(32'h33334444); expect_word(32'h55556666);
    in_valid = 1'b1; in_data = 32'h11112222;
    step();
    in_data = 32'h33334444;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_last", out_last, k % 2);
      if (k == 0) in_data = 32'h55556666; else in_valid = 1'b0;
      step();
    end
    chk("b2b_idle", out_valid, 0);
    chk("b2b_words_sent", words_sent, exp_ws);
    drain(4);

    // reset mid-transfer with 2 words queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hD0D00000 | i;
      step();
    end
    in_valid = 1'b0;
    chk("mid_count", count, 2);
    chk("mid_low_data", out_data, 16'h0000);
    chk("mid_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_words", words_sent, 0);
    exp_ws = 0;
    sb.delete();
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_quiet", out_valid, 0);
    end
    in_valid = 1'b1; in_data = 32'hCAFEF00D; expect_word(32'hCAFEF00D);
    step();
    in_valid = 1'b0;
    drain(10);
    chk("post_rst_words", words_sent, exp_ws);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, FIFO depth in 32-bit words (power of two, >= 2).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_ula, input, 1: sole clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- in_data, input, 32: result word from the ALU stage (its data_out).
- in_valid, input, 1: in_data valid for one cycle (the ALU stage's valid_out); no backpressure toward the ALU stage.
- clr_ovf, input, 1: synchronous clear of the overflow flag.
- out_data, output, 16: serialized output beat.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts the beat.
- out_last, output, 1: high on the upper-half beat of a word.
- count, output, clog2(DEPTH)+1: FIFO occupancy, excluding the word held in the serializer.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- overflow, output, 1: sticky flag, a result was dropped.
- words_sent, output, 16: completed-word counter.

Function
REQ-003 The FIFO SHALL push in_data on every rising edge where in_valid=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-004 When in_valid=1, count==DEPTH and no same-cycle pop, the word SHALL be discarded, the FIFO SHALL be unchanged, and overflow SHALL be set to 1 on that edge.
REQ-005 overflow SHALL stay set until an edge with clr_ovf=1 and no new drop; a new drop in the same cycle as clr_ovf SHALL win, leaving overflow=1.
REQ-006 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo DEPTH.
REQ-007 count SHALL be unchanged on a simultaneous push and pop, +1 on push only, and -1 on pop only.
REQ-008 The serializer FSM SHALL have three states: IDLE, LOW and HIGH.
REQ-009 In IDLE with count>0, the FSM SHALL load the FIFO head into a 32-bit hold register, pop the FIFO, and move to LOW on the next edge.
REQ-010 In IDLE, out_valid SHALL be 0.
REQ-011 In LOW, the block SHALL drive out_valid=1, out_data=hold[15:0] and out_last=0, and SHALL move to HIGH on an edge with out_ready=1.
REQ-012 In HIGH, the block SHALL drive out_valid=1, out_data=hold[31:16] and out_last=1.
REQ-013 In HIGH on an edge with out_ready=1, words_sent SHALL increment by 1, wrapping from 0xFFFF to 0.
REQ-014 On that same HIGH edge, if count>0 the FSM SHALL load and pop the next head and go to LOW (back-to-back, no bubble); otherwise it SHALL go to IDLE.
REQ-015 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-016 out_ready SHALL be ignored in IDLE.
REQ-017 Latency from an in_valid edge into an empty, idle block SHALL be 2 cycles: push at edge t, load at edge t+1, out_valid=1 after edge t+1.
REQ-018 Sustained throughput SHALL be one 32-bit word per two out_ready cycles.
REQ-019 The hold register SHALL be separate from the FIFO, so total buffering is DEPTH+1 words.

Reset
REQ-020 When rst=0, the block SHALL immediately and asynchronously set the state to IDLE, the pointers and count to 0, and overflow, words_sent, hold and out_data to 0, with out_valid=0, out_last=0, empty=1 and full=0.
REQ-021 On reset mid-transfer, the block SHALL discard buffered and partially sent words with no further output beats; after release, the first edge with rst=1 SHALL behave as a normal edge.

Verification
REQ-022 Single word: push 0xDEADBEEF with out_ready=1 -> beats 0xBEEF (last=0), then 0xDEAD (last=1); words_sent=1; empty=1.
REQ-023 Backpressure: push 0x12345678 with out_ready=0 for 5 cycles -> out_data holds 0x5678 stable; when ready rises, 0x5678 then 0x1234.
REQ-024 Overflow: out_ready=0, push 6 words on consecutive cycles (DEPTH=4) -> words 1-5 kept (1 in hold, 4 in FIFO), word 6 dropped, overflow=1, full=1; then clr_ovf=1 -> overflow=0.
REQ-025 Full-with-pop: FIFO full, in_valid coincides with the HIGH-beat handshake that pops the FIFO -> word accepted, count stays 4, overflow stays 0.
REQ-026 Back-to-back: push 3 words, out_ready=1 -> 6 consecutive beats with no bubble, out_last pattern 0,1,0,1,0,1, words_sent=3.
REQ-027 Reset mid-operation: assert rst=0 during a LOW beat with 2 words queued -> outputs go to 0 immediately; after release, no stale beats are emitted.
